alu_exec_unit: RTL and testbench

- Execution-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decode, plus two XLEN operands.
- Produces the result and a zero flag for branch resolution.
- Add/sub/compare/logic ops complete in one cycle. Shifts use an iterative 1-bit-per-cycle shifter to save area.
- Valid/ready handshakes on both sides, so the pipeline stalls while a shift is in progress.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_serial_shifter.sv | 61 ++++++
 rtl/alu_exec_unit.sv | 122 ++++++++++++
 tb/tb_alu_exec_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : alu_pkg                                                      |
// | Purpose  : ALU opcodes and execution-unit state encodings shared by the |
// |            ALU control decode and the execution unit.                   |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_serial_shifter.sv
// ---------------------------------------------------------------------------
// | Module   : alu_serial_shifter                                           |
// | Purpose  : Iterative 1-bit-per-cycle shifter (SLL/SRL/SRA).             |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module alu_serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [XLEN-1:0]    load_data,
  input  logic [SHAMT_W-1:0] load_shamt,
  input  logic               load_left,
  input  logic               load_arith,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    shift_nxt
);

  logic [XLEN-1:0]    r_data;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_left;
  logic               r_arith;
  logic               r_busy;

  // done flags the cycle in which the final shift is applied, so the caller
  // can capture shift_nxt on the same edge.
  assign busy = r_busy;
  assign done = r_busy && (r_cnt == SHAMT_W'(1));
  assign shift_nxt = r_left ? {r_data[XLEN-2:0], 1'b0}
                            : {r_arith & r_data[XLEN-1], r_data[XLEN-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_arith <= 1'b0;
      r_busy  <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_cnt   <= load_shamt;
      r_left  <= load_left;
      r_arith <= load_arith;
      r_busy  <= (load_shamt != '0);
    end else if (r_busy) begin
      r_data <= shift_nxt;
      r_cnt  <= r_cnt - SHAMT_W'(1);
      if (r_cnt == SHAMT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// | Module   : alu_exec_unit                                                |
// | Purpose  : Execution-stage ALU with valid/ready handshakes; single-cycle |
// |            arithmetic/logic ops and iterative shifts.                   |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op
);

  state_t             r_state;
  logic               w_accept;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_alu_res;
  logic               w_illegal;
  logic               w_sh_busy;
  logic               w_sh_done;
  logic [XLEN-1:0]    w_sh_nxt;

  assign in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_is_shift = is_shift_op(alu_control);
  assign w_shamt    = op_b[SHAMT_W-1:0];

  // Shift codes return op_a here: that is the answer when shamt is zero.
  always_comb begin
    w_alu_res = '0;
    w_illegal = 1'b0;
    case (alu_control)
      ALU_ADD:  w_alu_res = op_a + op_b;
      ALU_SUB:  w_alu_res = op_a - op_b;
      ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  w_alu_res = op_a ^ op_b;
      ALU_OR:   w_alu_res = op_a | op_b;
      ALU_AND:  w_alu_res = op_a & op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = op_a;
      default:  w_illegal = 1'b1;
    endcase
  end

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_accept && w_is_shift),
    .load_data  (op_a),
    .load_shamt (w_shamt),
    .load_left  (alu_control == ALU_SLL),
    .load_arith (alu_control == ALU_SRA),
    .busy       (w_sh_busy),
    .done       (w_sh_done),
    .shift_nxt  (w_sh_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_state   <= SHIFT;
              out_valid <= 1'b0;
            end else begin
              r_state    <= DONE;
              out_valid  <= 1'b1;
              result     <= w_alu_res;
              zero       <= (w_alu_res == '0);
              illegal_op <= w_illegal;
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_sh_done || !w_sh_busy) begin
            r_state    <= DONE;
            out_valid  <= 1'b1;
            result     <= w_sh_nxt;
            zero       <= (w_sh_nxt == '0);
            illegal_op <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// | Module   : tb_alu_exec_unit                                             |
// | Purpose  : Scoreboard bench for alu_exec_unit with directed vectors.    |
// | Revision : 1.0  initial release                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_exec_unit;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_control = 4'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic eill,
                       input bit push);
    int guard;
    exp_t e;
    in_valid    = 1'b1;
    alu_control = op;
    op_a        = a;
    op_b        = b;
    if (push) begin
      e.res  = er;
      e.zero = (er == 32'd0);
      e.ill  = eill;
      exp_q.push_back(e);
      name_q.push_back(name);
    end
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept: in_ready stuck low, required 1", name);
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    alu_control = 4'hE;
    op_a        = 32'hA5A5A5A5;
    op_b        = 32'h5A5A5A5A;
  endtask

  // Counts negedges from accept until out_valid, and stalled cycles on the way.
  task automatic measure(input string name, input int exp_lat, input int exp_low);
    int n;
    int low;
    bit seen;
    n = 0;
    low = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (out_valid) seen = 1;
      else if (!in_ready) low++;
    end
    check({name, "_latency"}, n, exp_lat);
    check({name, "_stall"}, low, exp_low);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares on every output handshake.
  initial begin
    exp_t e;
    string nm;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: result=%h required no output", result);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if ({result, zero, illegal_op} !== {e.res, e.zero, e.ill}) begin
            n_fail++;
            $display("FAIL %s: result=%h zero=%b illegal=%b required result=%h zero=%b illegal=%b",
                     nm, result, zero, illegal_op, e.res, e.zero, e.ill);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue("add_5_7", OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1);
    measure("add_5_7", 1, 0);
    issue("sub_eq", OP_SUB, 32'h1234, 32'h1234, 32'd0, 1'b0, 1);
    measure("sub_eq", 1, 0);
    issue("slt_neg", OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1);
    measure("slt_neg", 1, 0);
    issue("sltu_big", OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
    measure("sltu_big", 1, 0);
    issue("sra_4", OP_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1);
    measure("sra_4", 5, 4);
    issue("sll_0x25", OP_SLL, 32'd1, 32'h25, 32'h20, 1'b0, 1);
    measure("sll_0x25", 6, 5);
    issue("srl_sh0", OP_SRL, 32'hDEADBEEF, 32'h20, 32'hDEADBEEF, 1'b0, 1);
    measure("srl_sh0", 1, 0);
    issue("sra_31", OP_SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0, 1);
    measure("sra_31", 32, 31);
    issue("srl_31", OP_SRL, 32'h80000000, 32'd31, 32'd1, 1'b0, 1);
    measure("srl_31", 32, 31);
    issue("sll_3", OP_SLL, 32'h80000001, 32'd3, 32'h00000008, 1'b0, 1);
    measure("sll_3", 4, 3);
    issue("or_f0_0f", OP_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1);
    measure("or_f0_0f", 1, 0);
    issue("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1);
    measure("add_wrap", 1, 0);

    // Backpressure, then a back-to-back accept while releasing it.
    out_ready = 1'b0;
    issue("and_bp", OP_AND, 32'h3F, 32'h0F, 32'h0F, 1'b0, 1);
    measure("and_bp", 1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {out_valid, in_ready, zero, result[28:0]}, {1'b1, 1'b0, 1'b0, 29'h0F});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue("add_b2b", OP_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1);
    measure("add_b2b", 1, 0);

    issue("illegal_f", 4'hF, 32'h11, 32'h22, 32'd0, 1'b1, 1);
    measure("illegal_f", 1, 0);
    issue("add_after_ill", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);
    measure("add_after_ill", 1, 0);
    issue("illegal_a", 4'hA, 32'h1, 32'h1, 32'd0, 1'b1, 1);
    measure("illegal_a", 1, 0);
    issue("xor_after_ill", OP_XOR, 32'h5, 32'h3, 32'h6, 1'b0, 1);
    measure("xor_after_ill", 1, 0);

    // Asynchronous reset in the middle of a long shift.
    issue("srl_abort", OP_SRL, 32'hFFFFFFFF, 32'd20, 32'd0, 1'b0, 0);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_zero", {31'd0, zero}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    issue("xor_ff_0f", OP_XOR, 32'hFF, 32'h0F, 32'hF0, 1'b0, 1);
    measure("xor_ff_0f", 1, 0);

    g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
